btb_update_controller: RTL and testbench

BTB_UPDATE_CONTROLLER -- requirements
Module: btb_update_controller

---
 rtl/btb_update_controller.sv | 157 +++++++++++++++
 tb/tb_btb_update_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_controller.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_controller
//  Description : Arbitrates resolved-branch updates from two requesters into
//                a single registered BTB write port, and runs a full-table
//                invalidation sweep on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_update_controller #(
    parameter int PC_SIZE     = 16,
    parameter int BTB_PC_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    // Requester 0
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [PC_SIZE-1:0]            req0_pc,
    input  logic                          req0_taken,
    input  logic [PC_SIZE-1:0]            req0_target,

    // Requester 1
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [PC_SIZE-1:0]            req1_pc,
    input  logic                          req1_taken,
    input  logic [PC_SIZE-1:0]            req1_target,

    // Flush control
    input  logic                          flush_req,
    output logic                          flush_busy,

    // BTB write port
    output logic                          wr_en,
    output logic [BTB_PC_BITS-1:0]        wr_idx,
    output logic                          wr_entry_valid,
    output logic [PC_SIZE-BTB_PC_BITS-1:0] wr_tag,
    output logic                          wr_branch,
    output logic [PC_SIZE-1:0]            wr_target
);

    localparam int                     c_TAG_BITS = PC_SIZE - BTB_PC_BITS;
    localparam logic [BTB_PC_BITS-1:0] c_CNT_LAST = {BTB_PC_BITS{1'b1}};

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [BTB_PC_BITS-1:0] r_cnt;
    logic                   r_prefer1;     // 1: req1 wins the next tie
    logic                   r_flush_busy;

    logic                   r_wr_en;
    logic [BTB_PC_BITS-1:0] r_wr_idx;
    logic                   r_wr_entry_valid;
    logic [c_TAG_BITS-1:0]  r_wr_tag;
    logic                   r_wr_branch;
    logic [PC_SIZE-1:0]     r_wr_target;

    // ------------------------------------------------------------------------
    // Arbitration (combinational ready)
    // ------------------------------------------------------------------------
    logic               w_arb_open;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic [PC_SIZE-1:0] w_sel_pc;
    logic               w_sel_taken;
    logic [PC_SIZE-1:0] w_sel_target;

    // A flush request or reset closes the arbiter for the cycle so nothing
    // is accepted that the sweep would immediately overwrite.
    assign w_arb_open = !rst && (r_state == c_ST_IDLE) && !flush_req;

    // Lone requester always wins; on a tie the round-robin pointer decides.
    assign w_gnt0 = w_arb_open && req0_valid && (!req1_valid || !r_prefer1);
    assign w_gnt1 = w_arb_open && req1_valid && (!req0_valid ||  r_prefer1);
    assign w_accept = w_gnt0 || w_gnt1;

    assign w_sel_pc     = w_gnt1 ? req1_pc     : req0_pc;
    assign w_sel_taken  = w_gnt1 ? req1_taken  : req0_taken;
    assign w_sel_target = w_gnt1 ? req1_target : req0_target;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // ------------------------------------------------------------------------
    // FSM, sweep counter, round-robin pointer and registered write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_cnt            <= '0;
            r_prefer1        <= 1'b0;
            r_flush_busy     <= 1'b0;
            r_wr_en          <= 1'b0;
            r_wr_idx         <= '0;
            r_wr_entry_valid <= 1'b0;
            r_wr_tag         <= '0;
            r_wr_branch      <= 1'b0;
            r_wr_target      <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (flush_req) begin
                        r_state      <= c_ST_FLUSH;
                        r_cnt        <= '0;
                        r_flush_busy <= 1'b1;
                    end else if (w_accept) begin
                        r_wr_en          <= 1'b1;
                        r_wr_idx         <= w_sel_pc[BTB_PC_BITS-1:0];
                        r_wr_tag         <= w_sel_pc[PC_SIZE-1:BTB_PC_BITS];
                        r_wr_entry_valid <= 1'b1;
                        r_wr_branch      <= w_sel_taken;
                        r_wr_target      <= w_sel_target;
                        // The requester just served loses the next tie.
                        r_prefer1        <= w_gnt0;
                    end
                end
                c_ST_FLUSH: begin
                    // flush_req is deliberately ignored here: a sweep in
                    // progress is neither restarted nor extended.
                    r_wr_en          <= 1'b1;
                    r_wr_idx         <= r_cnt;
                    r_wr_tag         <= '0;
                    r_wr_entry_valid <= 1'b0;
                    r_wr_branch      <= 1'b0;
                    r_wr_target      <= '0;
                    r_cnt            <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state      <= c_ST_IDLE;
                        r_flush_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_flush_busy <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy     = r_flush_busy;
    assign wr_en          = r_wr_en;
    assign wr_idx         = r_wr_idx;
    assign wr_entry_valid = r_wr_entry_valid;
    assign wr_tag         = r_wr_tag;
    assign wr_branch      = r_wr_branch;
    assign wr_target      = r_wr_target;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_update_controller
//  Description : Directed self-checking bench for btb_update_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_controller;

    localparam int c_PC  = 16;
    localparam int c_IDX = 4;

    logic              clk;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [c_PC-1:0]   req0_pc, req1_pc, req0_target, req1_target;
    logic              req0_taken, req1_taken;
    logic              flush_req, flush_busy;
    logic              wr_en, wr_entry_valid, wr_branch;
    logic [c_IDX-1:0]  wr_idx;
    logic [c_PC-c_IDX-1:0] wr_tag;
    logic [c_PC-1:0]   wr_target;

    int n_pass;
    int n_total;

    btb_update_controller #(
        .PC_SIZE     (c_PC),
        .BTB_PC_BITS (c_IDX)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_pc        (req0_pc),
        .req0_taken     (req0_taken),
        .req0_target    (req0_target),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_pc        (req1_pc),
        .req1_taken     (req1_taken),
        .req1_target    (req1_target),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_entry_valid (wr_entry_valid),
        .wr_tag         (wr_tag),
        .wr_branch      (wr_branch),
        .wr_target      (wr_target)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] idx, input logic [11:0] tag_v,
                          input logic valid, input logic br, input logic [15:0] tgt);
        chk({tag, ".wr_en"},    wr_en, 1'b1);
        chk({tag, ".wr_idx"},   wr_idx, idx);
        chk({tag, ".wr_tag"},   wr_tag, tag_v);
        chk({tag, ".wr_valid"}, wr_entry_valid, valid);
        chk({tag, ".wr_branch"},wr_branch, br);
        chk({tag, ".wr_target"},wr_target, tgt);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        flush_req = 1'b0;
        req0_valid = 1'b1; req0_pc = 16'h0; req0_taken = 1'b0; req0_target = 16'h0;
        req1_valid = 1'b1; req1_pc = 16'h0; req1_taken = 1'b0; req1_target = 16'h0;

        // ---------------- Reset state, ready held low under reset
        tick(); tick();
        @(negedge clk);
        chk("rst.ready0", req0_ready, 1'b0);
        chk("rst.ready1", req1_ready, 1'b0);
        chk("rst.wr_en",  wr_en, 1'b0);
        chk("rst.busy",   flush_busy, 1'b0);
        chk("rst.wr_target", wr_target, 16'h0);
        chk("rst.wr_idx", wr_idx, 4'h0);

        // ---------------- Single request from req0
        tick();
        rst = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_pc = 16'h1234; req0_taken = 1'b1; req0_target = 16'h2000;
        @(negedge clk);
        chk("single.ready0", req0_ready, 1'b1);
        chk("single.ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk_wr("single", 4'h4, 12'h123, 1'b1, 1'b1, 16'h2000);
        tick();
        @(negedge clk);
        chk("single.idle_wr_en", wr_en, 1'b0);

        // ---------------- Round-robin from reset with both requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_pc = 16'h1110; req0_taken = 1'b0; req0_target = 16'hA000;
        req1_valid = 1'b1; req1_pc = 16'h2225; req1_taken = 1'b1; req1_target = 16'hB000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d.ready0", i), req0_ready, (i % 2 == 0));
            chk($sformatf("rr%0d.ready1", i), req1_ready, (i % 2 == 1));
            if (i == 0) chk("rr0.wr_en", wr_en, 1'b0);
            else if (i % 2 == 1) chk_wr($sformatf("rr%0d", i), 4'h0, 12'h111, 1'b1, 1'b0, 16'hA000);
            else chk_wr($sformatf("rr%0d", i), 4'h5, 12'h222, 1'b1, 1'b1, 16'hB000);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk_wr("rr4", 4'h5, 12'h222, 1'b1, 1'b1, 16'hB000);

        // ---------------- Flush with req0 waiting; req0 served after sweep
        tick();
        flush_req = 1'b1;
        req0_valid = 1'b1; req0_pc = 16'h0042; req0_taken = 1'b1; req0_target = 16'h3333;
        @(negedge clk);
        chk("fl.req_cycle.ready0", req0_ready, 1'b0);
        chk("fl.req_cycle.busy", flush_busy, 1'b0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("fl.first.busy", flush_busy, 1'b1);
        chk("fl.first.wr_en", wr_en, 1'b0);
        chk("fl.first.ready0", req0_ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            @(negedge clk);
            chk_wr($sformatf("fl.sweep%0d", k), k[3:0], 12'h000, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("fl.sweep%0d.busy", k), flush_busy, (k < 15));
            chk($sformatf("fl.sweep%0d.ready0", k), req0_ready, (k == 15));
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk_wr("fl.after", 4'h2, 12'h004, 1'b1, 1'b1, 16'h3333);

        // ---------------- Flush re-pulse at sweep index 7 is ignored
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("rp.first.busy", flush_busy, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            flush_req = (k == 7);
            @(negedge clk);
            chk($sformatf("rp.sweep%0d.wr_en", k), wr_en, 1'b1);
            chk($sformatf("rp.sweep%0d.idx", k), wr_idx, k[3:0]);
            chk($sformatf("rp.sweep%0d.busy", k), flush_busy, (k < 15));
        end
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("rp.end.wr_en", wr_en, 1'b0);
        chk("rp.end.busy", flush_busy, 1'b0);

        // ---------------- Reset aborts a sweep at index 5
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("ab.sweep%0d.idx", k), wr_idx, k[3:0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1_valid = 1'b1; req1_pc = 16'h0ABC; req1_taken = 1'b0; req1_target = 16'h4444;
        @(negedge clk);
        chk("ab.wr_en", wr_en, 1'b0);
        chk("ab.busy", flush_busy, 1'b0);
        chk("ab.ready1", req1_ready, 1'b1);
        chk("ab.ready0", req0_ready, 1'b0);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk_wr("ab.req1", 4'hC, 12'h0AB, 1'b1, 1'b0, 16'h4444);
        tick();
        @(negedge clk);
        chk("ab.no_more_sweep", wr_en, 1'b0);

        // ---------------- Pointer follows last grant; nothing lost
        req1_valid = 1'b1; req1_pc = 16'h0206; req1_taken = 1'b1; req1_target = 16'h5000;
        @(negedge clk);
        tick();
        // first cycle with req1 only was the previous one; re-check it explicitly
        // by reading the write it produced next.
        req0_valid = 1'b1; req0_pc = 16'h0101; req0_taken = 1'b0; req0_target = 16'h6000;
        req1_pc = 16'h0207; req1_target = 16'h5001;
        @(negedge clk);
        chk_wr("pt.w0", 4'h6, 12'h020, 1'b1, 1'b1, 16'h5000);
        chk("pt.c1.ready0", req0_ready, 1'b1);
        chk("pt.c1.ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk_wr("pt.w1", 4'h1, 12'h010, 1'b1, 1'b0, 16'h6000);
        chk("pt.c2.ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk_wr("pt.w2", 4'h7, 12'h020, 1'b1, 1'b1, 16'h5001);
        tick();
        @(negedge clk);
        chk("pt.end.wr_en", wr_en, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
